// File: rtl/uart_rx_packer_pkg.sv
// Shared helpers for the UART receive byte packer.
package uart_rx_packer_pkg;

   localparam int MAX_BYTE_WIDTH = 16;

   // Low-contiguous byte-enable mask with n lanes set (n may equal MAX_BYTE_WIDTH).
   function automatic logic [MAX_BYTE_WIDTH-1:0] keep_mask(input int unsigned n);
      logic [MAX_BYTE_WIDTH:0] m;
      m = (17'(1) << n) - 17'(1);
      return m[MAX_BYTE_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/uart_rx_packer_if.sv
// Byte-in / word-out AXI-stream bundle around the packer; master is the packer side.
interface uart_rx_packer_if #(
   parameter int BYTE_WIDTH = 2
) ();

   logic                      i_tready;
   logic                      i_tvalid;
   logic [7:0]                i_tdata;
   logic                      o_tready;
   logic                      o_tvalid;
   logic [8*BYTE_WIDTH-1:0]   o_tdata;
   logic [BYTE_WIDTH-1:0]     o_tkeep;
   logic                      o_tlast;

   modport master (
      output i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast,
      input  i_tvalid, i_tdata, o_tready
   );

   modport slave (
      input  i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast,
      output i_tvalid, i_tdata, o_tready
   );

endinterface

// File: rtl/uart_rx_idle_timer.sv
// Saturating line-idle counter; expired is asserted on the IDLE_CYCLES-th enabled edge
// and stays asserted while the caller is unable to act on it.
module uart_rx_idle_timer #(
   parameter int IDLE_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic done,
   output logic expired
);

   localparam int TW    = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
   localparam int LIMIT = (IDLE_CYCLES > 0) ? IDLE_CYCLES : 1;

   logic [TW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear || done) begin
         count <= '0;
      end else if (enable && (count != TW'(LIMIT))) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (IDLE_CYCLES != 0) && enable && (int'(count) >= LIMIT - 1);

endmodule

// File: rtl/uart_rx_packer.sv
// Packs uart_rx bytes into BYTE_WIDTH-byte words; a word closes when full, on the
// delimiter byte (kept in the data), or when the serial link goes idle.
module uart_rx_packer
   import uart_rx_packer_pkg::*;
#(
   parameter int          BYTE_WIDTH  = 2,
   parameter int          IDLE_CYCLES = 1000,
   parameter int          EOP_EN      = 0,
   parameter logic [7:0]  EOP_BYTE    = 8'h0A
) (
   input logic              clk,
   input logic              rst,
   uart_rx_packer_if.master bus
);

   localparam int CW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam int DW = 8 * BYTE_WIDTH;

   logic [DW-1:0]             acc;
   logic [DW-1:0]             lane;
   logic [DW-1:0]             word;
   logic [CW-1:0]             cnt;
   logic                      slot_free;
   logic                      accept;
   logic                      is_eop;
   logic                      last_byte;
   logic                      emit;
   logic                      flush;
   logic                      expired;
   logic [MAX_BYTE_WIDTH-1:0] mask_emit;
   logic [MAX_BYTE_WIDTH-1:0] mask_flush;

   logic                      out_valid;
   logic [DW-1:0]             out_data;
   logic [BYTE_WIDTH-1:0]     out_keep;
   logic                      out_last;

   assign slot_free  = ~out_valid | bus.o_tready;
   assign accept     = bus.i_tvalid & slot_free;
   assign is_eop     = (EOP_EN != 0) && (bus.i_tdata == EOP_BYTE);
   assign last_byte  = ((int'(cnt) + 1) == BYTE_WIDTH);
   assign emit       = accept & (last_byte | is_eop);
   assign flush      = expired & slot_free & ~accept;
   assign mask_emit  = keep_mask(int'(cnt) + 1);
   assign mask_flush = keep_mask(int'(cnt));

   // Place the incoming byte in lane cnt; accumulator lanes at and above cnt are zero.
   always_comb begin
      lane = '0;
      for (int b = 0; b < BYTE_WIDTH; b++) begin
         if (cnt == CW'(b)) begin
            lane[8*b +: 8] = bus.i_tdata;
         end
      end
      word = acc | lane;
   end

   uart_rx_idle_timer #(
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept | (cnt == '0)),
      .enable  (~accept & (cnt != '0)),
      .done    (flush),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (emit || flush) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= word;
         cnt <= cnt + 1'b1;
      end
   end

   // An accepted byte always takes priority over an idle flush on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_keep  <= '0;
         out_last  <= 1'b0;
      end else if (emit) begin
         out_valid <= 1'b1;
         out_data  <= word;
         out_keep  <= mask_emit[BYTE_WIDTH-1:0];
         out_last  <= is_eop;
      end else if (flush) begin
         out_valid <= 1'b1;
         out_data  <= acc;
         out_keep  <= mask_flush[BYTE_WIDTH-1:0];
         out_last  <= 1'b1;
      end else if (bus.o_tready) begin
         out_valid <= 1'b0;
      end
   end

   assign bus.i_tready = slot_free;
   assign bus.o_tvalid = out_valid;
   assign bus.o_tdata  = out_data;
   assign bus.o_tkeep  = out_keep;
   assign bus.o_tlast  = out_last;

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer (2-byte words, 16-cycle idle flush, 0x0A delimiter)
// with a queue-based scoreboard drained by an independent output monitor.
module tb_uart_rx_packer;

   localparam int CLK_HALF = 5;

   typedef struct {
      logic [15:0] data;
      logic [1:0]  keep;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   uart_rx_packer_if #(.BYTE_WIDTH(2)) bus ();

   uart_rx_packer #(
      .BYTE_WIDTH  (2),
      .IDLE_CYCLES (16),
      .EOP_EN      (1),
      .EOP_BYTE    (8'h0A)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #CLK_HALF clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic expect_word(input logic [15:0] data, input logic [1:0] keep, input logic last);
      exp_t e;
      e.data = data;
      e.keep = keep;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Offer one byte and return #1 after the edge that accepted it.
   task automatic apply_stimulus(input logic [7:0] b);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      bus.i_tvalid = 1'b1;
      bus.i_tdata  = b;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         rdy = bus.i_tready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      bus.i_tvalid = 1'b0;
      if (!ok) check_output("byte_accept_timeout", 32'(b), 32'hFFFF_FFFF);
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200; t++) begin
         if (exp_q.size() == 0) break;
         step(1);
      end
      check_output("drain_queue_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // Each negedge with valid&ready is exactly one transfer at the following edge.
   always @(negedge clk) begin
      if (!rst && bus.o_tvalid && bus.o_tready) begin
         if (exp_q.size() == 0) begin
            check_output("unexpected_word", 32'(bus.o_tdata), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("word_tdata", 32'(bus.o_tdata), 32'(e.data));
            check_output("word_tkeep", 32'(bus.o_tkeep), 32'(e.keep));
            check_output("word_tlast", 32'(bus.o_tlast), 32'(e.last));
         end
      end
   end

   initial begin
      #(2 * CLK_HALF * 60000);
      errors++;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bus.i_tvalid = 1'b0;
      bus.i_tdata  = 8'h00;
      bus.o_tready = 1'b1;

      $display("[TB] reset and idle");
      rst = 1'b1;
      step(4);
      rst = 1'b0;
      check_output("reset_tvalid", 32'(bus.o_tvalid), 32'd0);
      check_output("reset_tdata", 32'(bus.o_tdata), 32'd0);
      check_output("reset_tlast", 32'(bus.o_tlast), 32'd0);
      for (int i = 0; i < 50; i++) begin
         step(1);
         check_output("idle_tvalid", 32'(bus.o_tvalid), 32'd0);
         check_output("idle_tkeep", 32'(bus.o_tkeep), 32'd0);
         check_output("idle_tready", 32'(bus.i_tready), 32'd1);
      end

      $display("[TB] full words");
      expect_word(16'h0100, 2'b11, 1'b0);
      expect_word(16'h0302, 2'b11, 1'b0);
      apply_stimulus(8'h00);
      check_output("half_word_no_valid", 32'(bus.o_tvalid), 32'd0);
      apply_stimulus(8'h01);
      check_output("word0_latency", 32'(bus.o_tvalid), 32'd1);
      apply_stimulus(8'h02);
      apply_stimulus(8'h03);
      check_output("word1_latency", 32'(bus.o_tvalid), 32'd1);
      wait_drain();

      $display("[TB] idle flush");
      expect_word(16'h0055, 2'b01, 1'b1);
      apply_stimulus(8'h55);
      step(15);
      check_output("flush_not_early", 32'(bus.o_tvalid), 32'd0);
      step(1);
      check_output("flush_at_16", 32'(bus.o_tvalid), 32'd1);
      wait_drain();

      expect_word(16'h5655, 2'b11, 1'b0);
      apply_stimulus(8'h55);
      step(15);
      apply_stimulus(8'h56);
      check_output("retime_valid", 32'(bus.o_tvalid), 32'd1);
      check_output("retime_tdata", 32'(bus.o_tdata), 32'h5655);
      wait_drain();

      $display("[TB] delimiter");
      expect_word(16'h0A41, 2'b11, 1'b1);
      expect_word(16'h000A, 2'b01, 1'b1);
      apply_stimulus(8'h41);
      apply_stimulus(8'h0A);
      apply_stimulus(8'h0A);
      check_output("eop_single_valid", 32'(bus.o_tvalid), 32'd1);
      wait_drain();

      $display("[TB] backpressure");
      bus.o_tready = 1'b0;
      step(1);
      expect_word(16'h0100, 2'b11, 1'b0);
      expect_word(16'h0302, 2'b11, 1'b0);
      expect_word(16'h0504, 2'b11, 1'b0);
      fork
         begin
            for (int b = 0; b < 6; b++) apply_stimulus(8'(b));
         end
         begin
            step(8);
            check_output("bp_tready_low", 32'(bus.i_tready), 32'd0);
            check_output("bp_held_valid", 32'(bus.o_tvalid), 32'd1);
            check_output("bp_held_tdata", 32'(bus.o_tdata), 32'h0100);
            bus.o_tready = 1'b1;
         end
      join
      wait_drain();

      bus.o_tready = 1'b0;
      expect_word(16'h0066, 2'b01, 1'b1);
      apply_stimulus(8'h66);
      step(16);
      check_output("bp_flush_valid", 32'(bus.o_tvalid), 32'd1);
      step(5);
      check_output("bp_flush_held", 32'(bus.o_tdata), 32'h0066);
      check_output("bp_flush_tready", 32'(bus.i_tready), 32'd0);
      bus.o_tready = 1'b1;
      wait_drain();

      $display("[TB] reset mid-word");
      apply_stimulus(8'h7E);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_output("midreset_tvalid", 32'(bus.o_tvalid), 32'd0);
      expect_word(16'h1110, 2'b11, 1'b0);
      apply_stimulus(8'h10);
      apply_stimulus(8'h11);
      wait_drain();
      step(40);
      check_output("final_no_stray", 32'(bus.o_tvalid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
